// File: rtl/systolic_feeder.sv
// Operand skewer for the 2x2 MAC systolic block: lane l of a k-step beat reaches the
// array l cycles after lane 0, one tile of INNER_DIMENSION beats, then an accumulator clear.

module systolic_feeder_lane #(
  parameter int WIDTH = 16,
  parameter int SKEW  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] west,
  output logic [WIDTH-1:0] north
);
  // sr[0] is the beat register; sr[1..SKEW] are the hold stages (hi_d for lane 1)
  logic [SKEW:0][2*WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= beat ? {a, b} : '0;
      for (int i = 1; i <= SKEW; i++) sr[i] <= sr[i-1];
    end
  end

  assign {west, north} = sr[SKEW];
endmodule

module systolic_feeder #(
  parameter int WIDTH           = 16,
  parameter int FRAC_WIDTH      = 8,
  parameter int BLOCK_SIZE      = 2,
  parameter int INNER_DIMENSION = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*WIDTH-1:0] s_a,
  input  logic [2*WIDTH-1:0] s_b,
  input  logic               accumulator_done,
  output logic [WIDTH-1:0]   in_west0,
  output logic [WIDTH-1:0]   in_west2,
  output logic [WIDTH-1:0]   in_north0,
  output logic [WIDTH-1:0]   in_north1,
  output logic               reset_acc,
  output logic               busy,
  output logic               tile_done
);
  localparam int CW = $clog2(INNER_DIMENSION + 1);
  localparam logic [CW-1:0] LAST = CW'(INNER_DIMENSION - 1);

  if (BLOCK_SIZE != 2 || FRAC_WIDTH >= WIDTH) begin : g_bad_cfg
    $error("systolic_feeder: only BLOCK_SIZE=2 with FRAC_WIDTH<WIDTH is supported");
  end

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, WAIT_ACC, CLEAR} state_t;

  state_t                           state;
  logic [CW-1:0]                    counter;
  logic                             beat;
  logic [BLOCK_SIZE-1:0][WIDTH-1:0] a_lane, b_lane, west, north;

  assign beat   = s_valid & s_ready;
  assign a_lane = s_a;
  assign b_lane = s_b;

  // Non-beat cycles load zeros, so bubbles shift both lanes alike and keep alignment
  for (genvar l = 0; l < BLOCK_SIZE; l++) begin : g_lane
    systolic_feeder_lane #(.WIDTH(WIDTH), .SKEW(l)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .beat  (beat),
      .a     (a_lane[l]),
      .b     (b_lane[l]),
      .west  (west[l]),
      .north (north[l])
    );
  end

  assign in_west0  = west[0];
  assign in_west2  = west[1];
  assign in_north0 = north[0];
  assign in_north1 = north[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      reset_acc <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      reset_acc <= 1'b0;
      tile_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= FEED;
          counter <= '0;
          s_ready <= 1'b1;
          busy    <= 1'b1;
        end
        FEED: if (beat) begin
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            state   <= DRAIN;
            s_ready <= 1'b0;
          end
        end
        DRAIN: state <= WAIT_ACC;
        WAIT_ACC: if (accumulator_done) begin
          state     <= CLEAR;
          reset_acc <= 1'b1;
          tile_done <= 1'b1;
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a 2-beat instance for directed scenarios and a 64-beat
// instance for a random-gap stream; expected lane words flow through a queue scoreboard.

module tb_systolic_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start, s_valid, acc_done, s_ready, busy, reset_acc, tile_done;
  logic [31:0] s_a, s_b;
  logic [15:0] w0, w2, n0, n1;

  logic        start_l, valid_l, done_l, ready_l, busy_l, reset_acc_l, tile_done_l;
  logic [31:0] a_l, b_l;
  logic [15:0] w0_l, w2_l, n0_l, n1_l;

  systolic_feeder #(.WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(2), .INNER_DIMENSION(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .accumulator_done(acc_done),
    .in_west0(w0), .in_west2(w2), .in_north0(n0), .in_north1(n1),
    .reset_acc(reset_acc), .busy(busy), .tile_done(tile_done)
  );

  systolic_feeder #(.WIDTH(16), .FRAC_WIDTH(8), .BLOCK_SIZE(2), .INNER_DIMENSION(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start_l), .s_valid(valid_l), .s_ready(ready_l),
    .s_a(a_l), .s_b(b_l), .accumulator_done(done_l),
    .in_west0(w0_l), .in_west2(w2_l), .in_north0(n0_l), .in_north1(n1_l),
    .reset_acc(reset_acc_l), .busy(busy_l), .tile_done(tile_done_l)
  );

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];   // {w0, n0, w2, n1}
  logic [31:0] m_hi;       // model's lane-1 hold: {a_hi, b_hi}
  int          m_cnt;
  bit          m_feed;

  localparam logic [31:0] A1 = 32'h0400_0200, B1 = 32'h0300_0200;
  localparam logic [31:0] A2 = 32'h0300_0100, B2 = 32'h0100_0400;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b);
    s_valid = v; s_a = a; s_b = b;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_feed = 1'b1; m_cnt = 0; m_hi = '0;
    exp_q.delete();
  endtask

  task automatic finish_tile();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    step();
  endtask

  // Reference: lane 0 is the current beat's lo halves, lane 1 the previous cycle's hi halves
  task automatic model_push(input bit v, input logic [31:0] a, input logic [31:0] b, input int id);
    logic [63:0] e;
    bit          bt;
    bt = v && m_feed;
    e  = {(bt ? a[15:0] : 16'h0), (bt ? b[15:0] : 16'h0), m_hi[31:16], m_hi[15:0]};
    m_hi = bt ? {a[31:16], b[31:16]} : 32'h0;
    if (bt) begin
      m_cnt++;
      if (m_cnt == id) m_feed = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [67:0] got;
    rst_n = 1'b0;
    start = 1'b1; s_valid = 1'b1; acc_done = 1'b1; s_a = $urandom; s_b = $urandom;
    start_l = 1'b1; valid_l = 1'b1; done_l = 1'b1; a_l = $urandom; b_l = $urandom;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {s_ready, busy, reset_acc, tile_done, w0, w2, n0, n1};
      tests++;
      if (got !== 68'd0) begin
        fails++; $display("FAIL reset_hold[%0d] got %h expected 0", i, got);
      end
      got = {ready_l, busy_l, reset_acc_l, tile_done_l, w0_l, w2_l, n0_l, n1_l};
      tests++;
      if (got !== 68'd0) begin
        fails++; $display("FAIL reset_hold64[%0d] got %h expected 0", i, got);
      end
    end
    start = 1'b0; s_valid = 1'b0; acc_done = 1'b0;
    start_l = 1'b0; valid_l = 1'b0; done_l = 1'b0;
    rst_n = 1'b1;
    step();
    got = {s_ready, busy, reset_acc, tile_done, w0, w2, n0, n1};
    tests++;
    if (got !== 68'd0) begin
      fails++; $display("FAIL reset_release got %h expected 0", got);
    end
  endtask

  task automatic test_skew();
    logic [63:0] got, e;
    logic [31:0] va[4], vb[4];
    bit          vv[4];
    do_start();
    tests++;
    if ({s_ready, busy} !== 2'b11) begin
      fails++; $display("FAIL skew_feed_entry got ready/busy=%b expected 11", {s_ready, busy});
    end
    exp_q.push_back({16'h0200, 16'h0200, 16'h0000, 16'h0000});
    exp_q.push_back({16'h0100, 16'h0400, 16'h0400, 16'h0300});
    exp_q.push_back({16'h0000, 16'h0000, 16'h0300, 16'h0100});
    exp_q.push_back(64'h0);
    // third cycle offers a valid beat while s_ready is low: it must not be consumed
    vv = '{1'b1, 1'b1, 1'b1, 1'b0};
    va = '{A1, A2, 32'hdead_beef, 32'h1234_5678};
    vb = '{B1, B2, 32'hcafe_f00d, 32'h8765_4321};
    for (int i = 0; i < 4; i++) begin
      drive(vv[i], va[i], vb[i]);
      got = {w0, n0, w2, n1};
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++; $display("FAIL skew[%0d] got %h expected %h", i, got, e);
      end
    end
    tests++;
    if ({s_ready, busy} !== 2'b01) begin
      fails++; $display("FAIL skew_wait_acc got ready/busy=%b expected 01", {s_ready, busy});
    end
    finish_tile();
  endtask

  task automatic test_bubble();
    logic [63:0] got, e;
    logic [31:0] va[5], vb[5];
    bit          vv[5];
    do_start();
    exp_q.push_back({16'h0200, 16'h0200, 16'h0000, 16'h0000});
    exp_q.push_back({16'h0000, 16'h0000, 16'h0400, 16'h0300});
    exp_q.push_back({16'h0100, 16'h0400, 16'h0000, 16'h0000});
    exp_q.push_back({16'h0000, 16'h0000, 16'h0300, 16'h0100});
    exp_q.push_back(64'h0);
    vv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    va = '{A1, 32'h7777_7777, A2, 32'h5555_5555, 32'h3333_3333};
    vb = '{B1, 32'h6666_6666, B2, 32'h4444_4444, 32'h2222_2222};
    for (int i = 0; i < 5; i++) begin
      drive(vv[i], va[i], vb[i]);
      got = {w0, n0, w2, n1};
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++; $display("FAIL bubble[%0d] got %h expected %h", i, got, e);
      end
    end
    finish_tile();
  endtask

  task automatic test_handshake();
    do_start();
    start = 1'b1;
    drive(1'b1, A1, B1);
    start = 1'b0;
    tests++;
    if ({s_ready, busy} !== 2'b11) begin
      fails++; $display("FAIL hs_start_in_feed got ready/busy=%b expected 11", {s_ready, busy});
    end
    drive(1'b1, A2, B2);
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({reset_acc, tile_done, busy, w0, n0, w2, n1} !== {3'b001, 64'h0} && i > 0) begin
        fails++; $display("FAIL hs_wait[%0d] got %h expected %h", i,
                          {reset_acc, tile_done, busy, w0, n0, w2, n1}, {3'b001, 64'h0});
      end else if ({reset_acc, tile_done, busy} !== 3'b001) begin
        fails++; $display("FAIL hs_wait[%0d] got rst/done/busy=%b expected 001", i,
                          {reset_acc, tile_done, busy});
      end
      step();
    end
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
    tests++;
    if ({reset_acc, tile_done, busy} !== 3'b111) begin
      fails++; $display("FAIL hs_clear got rst/done/busy=%b expected 111", {reset_acc, tile_done, busy});
    end
    start = 1'b1;   // start during CLEAR is dropped
    step();
    start = 1'b0;
    tests++;
    if ({reset_acc, tile_done, busy, s_ready} !== 4'b0000) begin
      fails++; $display("FAIL hs_after_clear got rst/done/busy/ready=%b expected 0000",
                        {reset_acc, tile_done, busy, s_ready});
    end
    step();
    tests++;
    if ({busy, s_ready} !== 2'b00) begin
      fails++; $display("FAIL hs_no_queue got busy/ready=%b expected 00", {busy, s_ready});
    end
    acc_done = 1'b1;   // ignored in IDLE
    step();
    acc_done = 1'b0;
    tests++;
    if ({reset_acc, tile_done, busy} !== 3'b000) begin
      fails++; $display("FAIL hs_done_in_idle got rst/done/busy=%b expected 000", {reset_acc, tile_done, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, e;
    logic [67:0] all;
    do_start();
    model_push(1'b1, A1, B1, 2);
    drive(1'b1, A1, B1);
    got = {w0, n0, w2, n1};
    e = exp_q.pop_front();
    tests++;
    if (got !== e) begin
      fails++; $display("FAIL midrst_beat got %h expected %h", got, e);
    end
    rst_n = 1'b0;
    #1;
    all = {s_ready, busy, reset_acc, tile_done, w0, w2, n0, n1};
    tests++;
    if (all !== 68'd0) begin
      fails++; $display("FAIL midrst_immediate got %h expected 0", all);
    end
    s_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    do_start();
    model_push(1'b1, A2, B2, 2);
    drive(1'b1, A2, B2);
    tests++;
    if (s_ready !== 1'b1) begin
      fails++; $display("FAIL midrst_restart_count got ready=%b expected 1", s_ready);
    end
    got = {w0, n0, w2, n1};
    e = exp_q.pop_front();
    tests++;
    if (got !== e) begin
      fails++; $display("FAIL midrst_new0 got %h expected %h", got, e);
    end
    model_push(1'b1, A1, B1, 2);
    drive(1'b1, A1, B1);
    tests++;
    if ({s_ready, busy} !== 2'b01) begin
      fails++; $display("FAIL midrst_drain got ready/busy=%b expected 01", {s_ready, busy});
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        model_push(1'b0, 32'h0, 32'h0, 2);
        drive(1'b0, 32'h0, 32'h0);
      end
      got = {w0, n0, w2, n1};
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++; $display("FAIL midrst_tail[%0d] got %h expected %h", i, got, e);
      end
    end
    finish_tile();
  endtask

  task automatic test_long();
    logic [63:0] got, e;
    logic [31:0] a, b;
    bit          v;
    int          cyc, post;
    start_l = 1'b1;
    step();
    start_l = 1'b0;
    m_feed = 1'b1; m_cnt = 0; m_hi = '0;
    exp_q.delete();
    cyc = 0; post = 0;
    while ((m_cnt < 64 || post < 2) && cyc < 2000) begin
      v = ($urandom_range(0, 2) != 0);
      a = $urandom; b = $urandom;
      if (m_feed) begin
        tests++;
        if (ready_l !== 1'b1) begin
          fails++; $display("FAIL long_ready[%0d] got %b expected 1", cyc, ready_l);
        end
      end else begin
        post++;
      end
      model_push(v, a, b, 64);
      valid_l = v; a_l = a; b_l = b;
      step();
      got = {w0_l, n0_l, w2_l, n1_l};
      e = exp_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++; $display("FAIL long_lanes[%0d] got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
    valid_l = 1'b0;
    tests++;
    if (m_cnt != 64 || post < 2) begin
      fails++; $display("FAIL long_budget got %0d beats expected 64", m_cnt);
    end
    tests++;
    if ({ready_l, busy_l, w0_l, n0_l, w2_l, n1_l} !== {2'b01, 64'h0}) begin
      fails++; $display("FAIL long_wait got %h expected %h", {ready_l, busy_l, w0_l, n0_l, w2_l, n1_l},
                        {2'b01, 64'h0});
    end
    done_l = 1'b1;
    step();
    done_l = 1'b0;
    tests++;
    if ({reset_acc_l, tile_done_l} !== 2'b11) begin
      fails++; $display("FAIL long_clear got rst/done=%b expected 11", {reset_acc_l, tile_done_l});
    end
    step();
    tests++;
    if ({reset_acc_l, tile_done_l, busy_l} !== 3'b000) begin
      fails++; $display("FAIL long_idle got rst/done/busy=%b expected 000", {reset_acc_l, tile_done_l, busy_l});
    end
  endtask

  initial begin
    start = 0; s_valid = 0; acc_done = 0; s_a = 0; s_b = 0;
    start_l = 0; valid_l = 0; done_l = 0; a_l = 0; b_l = 0;
    m_hi = 0; m_cnt = 0; m_feed = 0;
    test_reset();
    test_skew();
    test_bubble();
    test_handshake();
    test_reset_mid();
    test_long();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end
endmodule
